instruction_fetch: RTL and testbench

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/isa_pkg.sv | 20 ++
 rtl/fetch_buffer.sv | 71 +++++++
 rtl/instruction_fetch.sv | 109 ++++++++++
 tb/tb_instruction_fetch.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/isa_pkg.sv
// isa_pkg: shared ISA-level constants and the instruction fetch state type.
//   ADDR_W               - instruction address width
//   INSTR_W              - instruction word width
//   PROGRAM_LOAD_ADDRESS - address of the first instruction after boot
//   fetch_state_t        - instruction_fetch controller states
package isa_pkg;

    localparam int unsigned ADDR_W  = 10;
    localparam int unsigned INSTR_W = 37;

    localparam logic [ADDR_W-1:0] PROGRAM_LOAD_ADDRESS = 10'h200;

    typedef enum logic [1:0] {
        IDLE = 2'd0,  // ready for a new pc
        REQ  = 2'd1,  // imem_req asserted, waiting for grant
        WAIT = 2'd2,  // granted, waiting for read data
        DROP = 2'd3   // granted request was flushed; swallow its response
    } fetch_state_t;

endpackage

// File: rtl/fetch_buffer.sv
// fetch_buffer: small synchronous FIFO holding fetched {instr, pc} entries.
//   clk, reset_n  - clock, asynchronous active-low reset
//   push, wdata   - write one entry at the tail
//   pop           - remove the head entry
//   clear         - empty the FIFO; overrides push and pop
//   rdata         - head entry (valid when count != 0)
//   count         - current occupancy, 0..DEPTH
module fetch_buffer #(
    parameter int unsigned WIDTH = 47,
    parameter int unsigned DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    input  logic                       clear,
    output logic [WIDTH-1:0]           rdata,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             full;
    logic             empty;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == DEPTH_C);
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A push into a full FIFO is legal only when the head leaves the same cycle.
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: single-outstanding instruction fetch unit with an
// output FIFO toward decode.
//   clk, reset_n                - clock, asynchronous active-low reset
//   pc, pc_valid, pc_ready      - fetch address handshake from the PC stage
//   flush                       - redirect; discards buffered and in-flight work
//   imem_req, imem_addr         - memory request (held until imem_gnt)
//   imem_gnt                    - memory accepted the request
//   imem_rvalid, imem_rdata     - memory read response
//   instr_valid, instr, instr_pc- head of the fetch buffer toward decode
//   instr_ready                 - decode consumes the head entry
module instruction_fetch
    import isa_pkg::*;
#(
    parameter int unsigned ADDR_W    = isa_pkg::ADDR_W,
    parameter int unsigned INSTR_W   = isa_pkg::INSTR_W,
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [ADDR_W-1:0]  pc,
    input  logic               pc_valid,
    output logic               pc_ready,
    input  logic               flush,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_gnt,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               instr_valid,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc,
    input  logic               instr_ready
);

    localparam int unsigned ENTRY_W = INSTR_W + ADDR_W;
    localparam int unsigned CNT_W   = $clog2(BUF_DEPTH + 1);

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(BUF_DEPTH);

    fetch_state_t       state;
    fetch_state_t       state_nxt;
    logic               accept;
    logic               buf_push;
    logic               buf_pop;
    logic [ENTRY_W-1:0] buf_rdata;
    logic [CNT_W-1:0]   buf_count;

    // Gating on reset_n keeps pc_ready low for the whole reset assertion.
    assign pc_ready = reset_n && (state == IDLE) && (buf_count < DEPTH_C) && !flush;
    assign accept   = pc_valid && pc_ready;
    assign imem_req = (state == REQ);

    always_comb begin
        state_nxt = state;
        buf_push  = 1'b0;
        case (state)
            IDLE: begin
                if (accept) state_nxt = REQ;
            end
            REQ: begin
                // A grant coinciding with flush still owes us a response.
                if (flush)         state_nxt = imem_gnt ? DROP : IDLE;
                else if (imem_gnt) state_nxt = WAIT;
            end
            WAIT: begin
                if (flush) begin
                    state_nxt = imem_rvalid ? IDLE : DROP;
                end else if (imem_rvalid) begin
                    state_nxt = IDLE;
                    buf_push  = 1'b1;
                end
            end
            DROP: begin
                if (imem_rvalid) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            imem_addr <= '0;
        end else begin
            state <= state_nxt;
            if (accept) imem_addr <= pc;
        end
    end

    assign instr_valid = (buf_count != '0);
    assign buf_pop     = instr_valid && instr_ready;
    assign instr       = buf_rdata[ENTRY_W-1:ADDR_W];
    assign instr_pc    = buf_rdata[ADDR_W-1:0];

    fetch_buffer #(
        .WIDTH (ENTRY_W),
        .DEPTH (BUF_DEPTH)
    ) u_buf (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (buf_push),
        .wdata   ({imem_rdata, imem_addr}),
        .pop     (buf_pop),
        .clear   (flush),
        .rdata   (buf_rdata),
        .count   (buf_count)
    );

endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;
    import isa_pkg::*;

    logic        clk;
    logic        reset_n;
    logic [9:0]  pc;
    logic        pc_valid;
    logic        pc_ready;
    logic        flush;
    logic        imem_req;
    logic [9:0]  imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [36:0] imem_rdata;
    logic        instr_valid;
    logic [36:0] instr;
    logic [9:0]  instr_pc;
    logic        instr_ready;

    int checks   = 0;
    int failures = 0;

    instruction_fetch #(
        .ADDR_W    (10),
        .INSTR_W   (37),
        .BUF_DEPTH (2)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .pc          (pc),
        .pc_valid    (pc_valid),
        .pc_ready    (pc_ready),
        .flush       (flush),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_ready (instr_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Zero-wait fetch: accept, grant with req, response next cycle.
    task automatic fetch(input logic [9:0] a, input logic [36:0] d);
        pc = a; pc_valid = 1'b1;
        step();
        pc_valid = 1'b0; imem_gnt = 1'b1;
        step();
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = d;
        step();
        imem_rvalid = 1'b0; imem_rdata = '0;
    endtask

    initial begin
        reset_n = 1'b0; pc = '0; pc_valid = 1'b0; flush = 1'b0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0; instr_ready = 1'b0;
        step(); step();
        chk("rst_pc_ready",    64'(pc_ready), 64'd0);
        chk("rst_imem_req",    64'(imem_req), 64'd0);
        chk("rst_imem_addr",   64'(imem_addr), 64'd0);
        chk("rst_instr_valid", 64'(instr_valid), 64'd0);
        chk("rst_instr",       64'(instr), 64'd0);
        chk("rst_instr_pc",    64'(instr_pc), 64'd0);
        reset_n = 1'b1;
        #1;
        chk("post_rst_pc_ready", 64'(pc_ready), 64'd1);

        // Minimum-latency fetch from the program load address
        pc = PROGRAM_LOAD_ADDRESS; pc_valid = 1'b1;
        chk("c0_pc_ready", 64'(pc_ready), 64'd1);
        step();
        pc_valid = 1'b0;
        chk("c1_imem_req",  64'(imem_req), 64'd1);
        chk("c1_imem_addr", 64'(imem_addr), 64'h200);
        chk("c1_pc_ready",  64'(pc_ready), 64'd0);
        imem_gnt = 1'b1;
        step();
        imem_gnt = 1'b0;
        chk("c2_imem_req",    64'(imem_req), 64'd0);
        chk("c2_instr_valid", 64'(instr_valid), 64'd0);
        imem_rvalid = 1'b1; imem_rdata = 37'h0_1234_5678;
        step();
        imem_rvalid = 1'b0; imem_rdata = '0;
        chk("c3_instr_valid", 64'(instr_valid), 64'd1);
        chk("c3_instr",       64'(instr), 64'h0_1234_5678);
        chk("c3_instr_pc",    64'(instr_pc), 64'h200);
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;
        chk("pop_instr_valid", 64'(instr_valid), 64'd0);

        // Fill the buffer with decode stalled
        fetch(10'h200, 37'h1_0000_0001);
        fetch(10'h201, 37'h0_ABCD_EF01);
        chk("full_count",    64'(dut.buf_count), 64'd2);
        chk("full_pc_ready", 64'(pc_ready), 64'd0);
        pc = 10'h202; pc_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("full_no_req", 64'(imem_req), 64'd0);
        end
        chk("full_head_pc",   64'(instr_pc), 64'h200);
        chk("full_head_data", 64'(instr), 64'h1_0000_0001);
        pc_valid = 1'b0;

        // Flush coincident with a pop of the full buffer
        flush = 1'b1; instr_ready = 1'b1;
        chk("flush_pc_ready", 64'(pc_ready), 64'd0);
        step();
        flush = 1'b0; instr_ready = 1'b0;
        chk("flushpop_count", 64'(dut.buf_count), 64'd0);
        chk("flushpop_valid", 64'(instr_valid), 64'd0);
        step();
        chk("flushpop_valid2", 64'(instr_valid), 64'd0);

        // Flush in WAIT, response arrives two cycles later
        pc = 10'h205; pc_valid = 1'b1;
        step();
        pc_valid = 1'b0; imem_gnt = 1'b1;
        step();
        imem_gnt = 1'b0; flush = 1'b1;
        step();
        flush = 1'b0;
        chk("wflush_state", 64'(dut.state), 64'(DROP));
        chk("wflush_pc_ready_a", 64'(pc_ready), 64'd0);
        step();
        chk("wflush_pc_ready_b", 64'(pc_ready), 64'd0);
        imem_rvalid = 1'b1; imem_rdata = 37'h1F_FFFF_FFFF;
        step();
        imem_rvalid = 1'b0; imem_rdata = '0;
        chk("wflush_pc_ready_c", 64'(pc_ready), 64'd1);
        chk("wflush_valid",      64'(instr_valid), 64'd0);
        chk("wflush_count",      64'(dut.buf_count), 64'd0);

        // Flush in REQ together with grant -> must drop the response
        pc = 10'h210; pc_valid = 1'b1;
        step();
        pc_valid = 1'b0; flush = 1'b1; imem_gnt = 1'b1;
        step();
        flush = 1'b0; imem_gnt = 1'b0;
        chk("rflushg_state", 64'(dut.state), 64'(DROP));
        chk("rflushg_req",   64'(imem_req), 64'd0);
        imem_rvalid = 1'b1; imem_rdata = 37'h0_0000_BEEF;
        step();
        imem_rvalid = 1'b0;
        chk("rflushg_idle",  64'(dut.state), 64'(IDLE));
        chk("rflushg_valid", 64'(instr_valid), 64'd0);

        // Flush in REQ without grant -> straight back to IDLE
        pc = 10'h211; pc_valid = 1'b1;
        step();
        pc_valid = 1'b0; flush = 1'b1;
        step();
        flush = 1'b0;
        chk("rflush_state", 64'(dut.state), 64'(IDLE));
        chk("rflush_req",   64'(imem_req), 64'd0);

        // Flush in WAIT with a coincident response -> data discarded, IDLE
        pc = 10'h212; pc_valid = 1'b1;
        step();
        pc_valid = 1'b0; imem_gnt = 1'b1;
        step();
        imem_gnt = 1'b0; flush = 1'b1; imem_rvalid = 1'b1; imem_rdata = 37'h0_0000_1111;
        step();
        flush = 1'b0; imem_rvalid = 1'b0;
        chk("wflushr_state", 64'(dut.state), 64'(IDLE));
        chk("wflushr_valid", 64'(instr_valid), 64'd0);

        // Grant delayed four cycles
        pc = 10'h2AB; pc_valid = 1'b1;
        step();
        pc = 10'h3FF; pc_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("slow_req",  64'(imem_req), 64'd1);
            chk("slow_addr", 64'(imem_addr), 64'h2AB);
            step();
        end
        chk("slow_req_gnt", 64'(imem_req), 64'd1);
        imem_gnt = 1'b1;
        step();
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 37'h1_2345_6789;
        step();
        imem_rvalid = 1'b0;
        chk("slow_count", 64'(dut.buf_count), 64'd1);
        chk("slow_pc",    64'(instr_pc), 64'h2AB);
        chk("slow_data",  64'(instr), 64'h1_2345_6789);
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;

        // Reset during WAIT, stray response after release
        pc = 10'h3C0; pc_valid = 1'b1;
        step();
        pc_valid = 1'b0; imem_gnt = 1'b1;
        step();
        imem_gnt = 1'b0;
        chk("pre_rst_state", 64'(dut.state), 64'(WAIT));
        #2 reset_n = 1'b0;
        #1;
        chk("midrst_state",    64'(dut.state), 64'(IDLE));
        chk("midrst_addr",     64'(imem_addr), 64'd0);
        chk("midrst_pc_ready", 64'(pc_ready), 64'd0);
        step();
        reset_n = 1'b1; imem_rvalid = 1'b1; imem_rdata = 37'h0_DEAD_BEEF;
        step();
        imem_rvalid = 1'b0;
        chk("stray_count",    64'(dut.buf_count), 64'd0);
        chk("stray_valid",    64'(instr_valid), 64'd0);
        chk("stray_state",    64'(dut.state), 64'(IDLE));
        chk("stray_pc_ready", 64'(pc_ready), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
